// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard frame receiver with show-ahead scancode FIFO and sticky error flags.
//   clk, reset (async active-low)      : system clock and reset
//   psclk, psdata                      : raw asynchronous PS/2 lines
//   rd_en                              : pop FIFO head (ignored when empty)
//   err_clr                            : clear sticky flags (a set in the same cycle wins)
//   rx_data, rx_valid, count           : FIFO head, not-empty, occupancy
//   parity_err, frame_err, overflow    : sticky error flags
module ps2_keyboard_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   psclk,
  input  logic                   psdata,
  input  logic                   rd_en,
  input  logic                   err_clr,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par, r_push;
  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr, r_rd;
  logic          w_flip, w_fe, w_bit, w_tout, w_push, w_set_par, w_set_frm;
  logic          w_full, w_pop, w_wr;
  // The filtered clock flips on the FILTER_LEN-th consecutive sample that differs from it.
  assign w_flip = (r_clk_s[1] != r_filt) && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_fe   = w_flip && r_filt;
  assign w_bit  = r_dat_s[1];
  assign w_tout = (r_state != IDLE) && (r_tcnt == TW'(TIMEOUT - 1));
  // Lines idle high, so synchronizers and filter come out of reset at 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_filt  <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], psclk};
      r_dat_s <= {r_dat_s[0], psdata};
      r_fcnt  <= (r_clk_s[1] == r_filt || w_flip) ? '0 : r_fcnt + FW'(1);
      if (w_flip) r_filt <= r_clk_s[1];
    end
  end
  // A falling edge arriving on the last allowed cycle is still honoured ahead of the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_set_par   = 1'b0;
    w_set_frm   = 1'b0;
    if (w_fe) begin
      case (r_state)
        IDLE:    if (w_bit) w_set_frm = 1'b1; else w_state_nxt = DATA;
        DATA:    w_state_nxt = (r_bitcnt == 3'd7) ? PARITY : DATA;
        PARITY:  w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          w_push      = w_bit & (^{r_shift, r_par});
          w_set_par   = w_bit & ~(^{r_shift, r_par});
          w_set_frm   = ~w_bit;
        end
      endcase
    end else if (w_tout) begin
      w_state_nxt = IDLE;
      w_set_frm   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_tcnt   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_push   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tcnt   <= (w_fe || r_state == IDLE) ? '0 : r_tcnt + TW'(1);
      r_push   <= w_push;
      if (w_fe && r_state == IDLE) r_bitcnt <= '0;
      if (w_fe && r_state == DATA) begin
        r_shift  <= {w_bit, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_fe && r_state == PARITY) r_par <= w_bit;
    end
  end
  // r_shift still holds the accepted byte on the push cycle: the next data bit is many cycles away.
  assign count    = r_wr - r_rd;
  assign rx_valid = count != '0;
  assign rx_data  = r_mem[r_rd[AW-1:0]];
  assign w_full   = count == (AW + 1)'(DEPTH);
  assign w_pop    = rd_en & rx_valid;
  assign w_wr     = r_push & (~w_full | w_pop);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= '{default: '0};
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr[AW-1:0]] <= r_shift;
        r_wr <= r_wr + (AW + 1)'(1);
      end
      if (w_pop) r_rd <= r_rd + (AW + 1)'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= w_set_par | (parity_err & ~err_clr);
      frame_err  <= w_set_frm | (frame_err & ~err_clr);
      overflow   <= (r_push & w_full & ~w_pop) | (overflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: scoreboard bench for ps2_keyboard_rx with a queue-based reference model.
module tb_ps2_keyboard_rx;
  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int DP = 8;
  localparam int H  = 40;
  logic       clk = 0, reset = 1, psclk = 1, psdata = 1, rd_en = 0, err_clr = 0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overflow;
  logic [3:0] count;
  int         total = 0, bad = 0;
  byte unsigned exp_q[$];
  bit         e_par = 0, e_frm = 0, e_ovf = 0;
  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .psclk(psclk), .psdata(psdata), .rd_en(rd_en), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask
  // Monitor: every accepted pop is checked against the head of the reference queue.
  always @(negedge clk) begin
    if (reset && rd_en && rx_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop: got %0h want nothing (model empty)", rx_data);
      end else begin
        byte unsigned e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          bad++;
          $display("FAIL pop: got %0h want %0h", rx_data, e);
        end
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clk_bit(bit b, bit gl, bit pop);
    psdata = b;
    cyc(H / 2);
    if (gl) begin
      psclk = 0;
      cyc(3);
      psclk = 1;
      cyc(H / 2 - 3);
    end else cyc(H / 2);
    psclk = 0;
    if (pop) begin
      cyc(10);
      rd_en = 1;
      cyc(1);
      rd_en = 0;
      cyc(H - 11);
    end else cyc(H);
    psclk = 1;
  endtask
  task automatic send(byte unsigned d, bit bpar, bit bstop, int nb, bit gl, bit pop);
    logic [10:0] f;
    f = {~bstop, (~^d) ^ bpar, d, 1'b0};
    for (int i = 0; i < nb; i++) clk_bit(f[i], gl && i == 4, pop && i == 10);
    psdata = 1;
    if (nb == 11) begin
      if (bstop) e_frm = 1;
      else if (bpar) e_par = 1;
      else if (exp_q.size() < DP) exp_q.push_back(d);
      else e_ovf = 1;
    end
  endtask
  task automatic check(string nm);
    @(negedge clk);
    chk({nm, ".count"}, count, exp_q.size());
    chk({nm, ".valid"}, rx_valid, exp_q.size() != 0);
    chk({nm, ".par"}, parity_err, e_par);
    chk({nm, ".frm"}, frame_err, e_frm);
    chk({nm, ".ovf"}, overflow, e_ovf);
    if (exp_q.size() != 0) chk({nm, ".head"}, rx_data, exp_q[0]);
    @(posedge clk);
    #1;
  endtask
  task automatic pop_one();
    rd_en = 1;
    cyc(1);
    rd_en = 0;
  endtask
  task automatic clr();
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    e_par = 0;
    e_frm = 0;
    e_ovf = 0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #1 reset = 0;
    cyc(3);
    @(negedge clk);
    chk("reset.data", rx_data, 0);
    check("reset");
    reset = 1;
    cyc(20);
    send(8'h1C, 0, 0, 11, 0, 0);
    check("t1");
    pop_one();
    check("t1pop");
    send(8'h1C, 1, 0, 11, 0, 0);
    check("t2");
    clr();
    check("t2clr");
    for (int i = 1; i <= 9; i++) send(byte'(i), 0, 0, 11, 0, 0);
    check("t3");
    for (int i = 0; i < 8; i++) pop_one();
    check("t3drain");
    pop_one();
    check("underflow");
    clr();
    for (int i = 1; i <= 8; i++) send(byte'(i), 0, 0, 11, 0, 0);
    send(8'h09, 0, 0, 11, 0, 1);
    check("t4");
    for (int i = 0; i < 8; i++) pop_one();
    check("t4drain");
    send(8'h5A, 0, 0, 5, 0, 0);
    cyc(TO + 50);
    e_frm = 1;
    check("t5");
    clr();
    send(8'hF0, 0, 0, 11, 0, 0);
    check("t5next");
    pop_one();
    send(8'hAA, 0, 0, 11, 1, 0);
    check("t6");
    send(8'h3C, 1, 0, 11, 0, 0);
    send(8'h33, 0, 0, 4, 0, 0);
    check("t6pre");
    reset = 0;
    exp_q.delete();
    e_par = 0;
    e_frm = 0;
    e_ovf = 0;
    @(negedge clk);
    chk("t6rst.data", rx_data, 0);
    check("t6rst");
    cyc(5);
    reset = 1;
    cyc(5);
    clk_bit(1, 0, 0);
    psdata = 1;
    e_frm = 1;
    check("t6post");
    clr();
    for (int it = 0; it < 20; it++) begin
      int k;
      k = $urandom_range(0, 9);
      send(byte'($urandom), k == 0, k == 1, 11, 0, 0);
      if ($urandom_range(0, 3) == 0) clr();
      repeat ($urandom_range(0, 2)) pop_one();
      check("rand");
    end
    while (exp_q.size() != 0) pop_one();
    check("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
